if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word reads to instruction memory over a
//  req/ack handshake, and drives if_pc/if_inst into the IF/ID pipeline register.
//  Sits between the ctrl/branch logic and the IF/ID register. The IF/ID register is its only consumer.
//  Delivers one instruction per cycle with zero-wait memory. Absorbs memory wait states, stalls and branch redirects.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous reset, active-high (`RstEnable)
//  stall_i         in   1   downstream stall; hold if_* outputs
//  branch_flag_i   in   1   one-cycle redirect request
//  branch_target_i in   32  redirect address; bits[1:0] forced to 0
//  imem_req_o      out  1   memory read request (ce)
//  imem_addr_o     out  32  read address; stable while req high and no ack
//  imem_ack_i      in   1   read complete; rdata valid this cycle
//  imem_rdata_i    in   32  read data
//  if_pc_o         out  32  PC of delivered instruction
//  if_inst_o       out  32  delivered instruction; `ZeroWord = nop bubble
//  if_valid_o      out  1   if_inst_o is a real fetched instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state IDLE, squash=0, imem_req_o=0, if_pc_o=0, if_inst_o=0, if_valid_o=0. rst beats all inputs.
//  States:
//   IDLE: entered only via reset. Go to FETCH the next cycle.
//   FETCH: imem_req_o=1, imem_addr_o=pc.
//   HOLD: imem_req_o=0. Holds one returned word while stalled.
//  Handshake: imem_addr_o never changes while req=1 until ack. ack is ignored when req=0.
//  FETCH, ack, no squash, no stall, no branch:
//   if_pc_o<=pc, if_inst_o<=rdata, if_valid_o<=1, pc<=pc+4.
//   req stays high, so the next address goes out the next cycle. Latency is ack cycle + 1.
//  FETCH, no ack, no stall: if_inst_o<=`ZeroWord, if_valid_o<=0, if_pc_o held.
//  stall_i=1: if_pc_o/if_inst_o/if_valid_o all hold their values.
//   An ack during stall captures {pc, rdata} into the hold buffer, sets pc<=pc+4 and goes to HOLD.
//  HOLD & !stall_i: outputs<=hold buffer with valid=1. Go to FETCH.
//  Branch priority: branch > stall > normal.
//   The branch sets if_inst_o<=`ZeroWord and if_valid_o<=0 even while stalled.
//  Branch cases:
//   branch & ack in the same cycle: discard rdata, pc<=target, stay FETCH.
//   branch, req outstanding, no ack: latch the target and set squash. On the later ack, discard data,
//    pc<=latched target, clear squash. A second branch before that ack overwrites the latched target.
//   branch in HOLD: drop the held word, pc<=target, go to FETCH.
//  pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  Reset during an outstanding request: req drops the next cycle, and a late ack is ignored.
// STRUCTURE
//  defines.v gains: `FetchIdle/`FetchFetch/`FetchHold (2-bit state codes) and `InstWordStep (32'd4).
//  It already supplies `RstEnable, `ZeroWord, `InstAddrBus, `InstBus.
//  Sub-module fetch_hold_buf: 1-entry {pc, inst} register with load/clear.
//  The FSM, PC and squash logic stay in if_fetch.
// TESTING
//  Zero-wait memory (ack same cycle), 4 cycles after reset:
//   if_pc_o = 0, 4, 8, 12 on consecutive cycles, valid=1 on each.
//  Memory with 2 wait states: each instruction is preceded by 2 bubble cycles
//   (if_inst_o=0, valid=0), and imem_addr_o is stable across the waits.
//  Stall for 3 cycles with an ack on stall cycle 1: outputs are frozen.
//   On release, the held word appears with valid=1. req is low during HOLD. No instruction is lost or duplicated.
//  branch_flag_i=1, target=32'h100 while a request for 0x8 is outstanding:
//   the 0x8 data is discarded, the next issued address is 0x100, and the next valid output has if_pc_o=0x100.
//  RESET_PC=32'hFFFF_FFF8 with zero-wait memory:
//   if_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  Assert rst mid-wait, then ack the cycle after reset:
//   all outputs are 0, the ack is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic                RST_ENABLE     = 1'b1;
    localparam logic [INST_W-1:0]   ZERO_WORD      = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]   INST_WORD_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_FETCH = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_word_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer that parks a word returned while the pipeline is stalled.
module fetch_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_word_t word_i,
    output fetch_word_t word_o
);

    fetch_word_t word_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, absorbing wait states, stalls and branch redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              squash_q, squash_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              out_valid_q, out_valid_d;

    logic              hb_load, hb_clear;
    fetch_word_t       hb_in, hb_out;
    logic              ack;
    logic [ADDR_W-1:0] pc_inc, br_tgt;

    assign ack    = req_q & imem_ack_i;
    assign pc_inc = pc_q + INST_WORD_STEP;
    assign br_tgt = word_align(branch_target_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        squash_d    = squash_q;
        req_d       = req_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        hb_load     = 1'b0;
        hb_clear    = 1'b0;
        hb_in.pc    = pc_q;
        hb_in.inst  = imem_rdata_i;

        unique case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_FETCH;
                req_d   = 1'b1;
                if (branch_flag_i) begin
                    pc_d        = br_tgt;
                    out_inst_d  = ZERO_WORD;
                    out_valid_d = 1'b0;
                end
            end
            FETCH_FETCH: begin
                if (branch_flag_i) begin
                    out_inst_d  = ZERO_WORD;
                    out_valid_d = 1'b0;
                    // Address must stay put until ack, so a redirect with a
                    // request in flight is parked and applied on that ack.
                    if (ack) begin
                        pc_d     = br_tgt;
                        squash_d = 1'b0;
                    end else begin
                        tgt_d    = br_tgt;
                        squash_d = 1'b1;
                    end
                end else if (ack && squash_q) begin
                    pc_d     = tgt_q;
                    squash_d = 1'b0;
                    if (!stall_i) begin
                        out_inst_d  = ZERO_WORD;
                        out_valid_d = 1'b0;
                    end
                end else if (stall_i) begin
                    if (ack) begin
                        hb_load = 1'b1;
                        pc_d    = pc_inc;
                        state_d = FETCH_HOLD;
                        req_d   = 1'b0;
                    end
                end else if (ack) begin
                    out_pc_d    = pc_q;
                    out_inst_d  = imem_rdata_i;
                    out_valid_d = 1'b1;
                    pc_d        = pc_inc;
                end else begin
                    out_inst_d  = ZERO_WORD;
                    out_valid_d = 1'b0;
                end
            end
            FETCH_HOLD: begin
                if (branch_flag_i) begin
                    out_inst_d  = ZERO_WORD;
                    out_valid_d = 1'b0;
                    pc_d        = br_tgt;
                    hb_clear    = 1'b1;
                    state_d     = FETCH_FETCH;
                    req_d       = 1'b1;
                end else if (!stall_i) begin
                    out_pc_d    = hb_out.pc;
                    out_inst_d  = hb_out.inst;
                    out_valid_d = 1'b1;
                    state_d     = FETCH_FETCH;
                    req_d       = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            squash_q    <= 1'b0;
            req_q       <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= ZERO_WORD;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            squash_q    <= squash_d;
            req_q       <= req_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .word_i  (hb_in),
        .word_o  (hb_out)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign if_pc_o     = out_pc_q;
    assign if_inst_o   = out_inst_q;
    assign if_valid_o  = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random stall/branch/wait traffic,
// checked against an instruction-stream model of the fetch contract.
module tb_if_fetch;

    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, stall, branch, ack;
    logic [31:0] target, rdata;
    logic        req, valid;
    logic [31:0] addr, pc, inst;
    logic        req1, valid1, ack1;
    logic [31:0] addr1, pc1, inst1, rdata1;

    int          n_pass, n_total, deliveries;
    logic [31:0] exp_next, p_pc, p_inst;
    logic        p_valid;
    int          wait_cfg, left;
    logic        rand_wait, busy, force_ack;

    always #5 clk = ~clk;

    // Memory contents: a distinct word per address so data identifies its source.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    if_fetch dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
        .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .if_pc_o(pc),
        .if_inst_o(inst), .if_valid_o(valid)
    );

    // Second instance with a reset PC near the top of the address space.
    if_fetch #(.RESET_PC(RPC1)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0),
        .branch_target_i(32'h0), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_ack_i(ack1), .imem_rdata_i(rdata1), .if_pc_o(pc1),
        .if_inst_o(inst1), .if_valid_o(valid1)
    );
    assign ack1   = req1;
    assign rdata1 = memf(addr1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Memory responder: ack after wait_cfg (or random 0..2) idle cycles per request.
    task automatic mem_update();
        if (force_ack) begin
            ack = 1'b1; rdata = $urandom; busy = 1'b0;
        end else if (req !== 1'b1) begin
            ack = 1'b0; rdata = $urandom; busy = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                left = rand_wait ? int'($urandom_range(2, 0)) : wait_cfg;
            end
            if (left == 0) begin
                ack = 1'b1; busy = 1'b0; rdata = memf(addr);
            end else begin
                ack = 1'b0; left--; rdata = $urandom;
            end
        end
    endtask

    // One clock: apply current inputs, then check outputs against the stream model.
    task automatic step();
        logic e_rst, e_stall, e_branch, e_req, e_ack;
        logic [31:0] e_tgt, e_addr;
        e_rst = rst; e_stall = stall; e_branch = branch; e_tgt = target;
        e_req = req; e_ack = ack; e_addr = addr;
        @(posedge clk);
        #1;
        if (e_rst) begin
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_inst", inst, 32'h0);
            chk("rst_pc", pc, 32'h0);
            chk("rst_req", 32'(req), 32'h0);
            exp_next = 32'h0;
        end else begin
            if (e_req && !e_ack) begin
                chk("req_held", 32'(req), 32'h1);
                chk("addr_stable", addr, e_addr);
            end
            if (e_branch) begin
                chk("br_valid", 32'(valid), 32'h0);
                chk("br_inst", inst, 32'h0);
                chk("br_pc", pc, p_pc);
                exp_next = {e_tgt[31:2], 2'b00};
            end else if (e_stall) begin
                chk("stall_pc", pc, p_pc);
                chk("stall_inst", inst, p_inst);
                chk("stall_valid", 32'(valid), 32'(p_valid));
            end else if (valid) begin
                chk("stream_pc", pc, exp_next);
                chk("stream_inst", inst, memf(pc));
                exp_next = pc + 32'd4;
                deliveries++;
            end else begin
                chk("bubble_inst", inst, 32'h0);
                chk("bubble_pc", pc, p_pc);
            end
        end
        p_pc = pc; p_inst = inst; p_valid = valid;
        mem_update();
    endtask

    initial begin
        n_pass = 0; n_total = 0; deliveries = 0;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        ack = 1'b0; rdata = 32'h0; force_ack = 1'b0; rand_wait = 1'b0;
        wait_cfg = 0; left = 0; busy = 1'b0; exp_next = 32'h0;
        p_pc = 32'h0; p_inst = 32'h0; p_valid = 1'b0;

        // Reset, then zero-wait streaming on both instances.
        step(); step();
        chk("wrap_rst_valid", 32'(valid1), 32'h0);
        rst = 1'b0;
        step();
        chk("first_req", 32'(req), 32'h1);
        chk("first_addr", addr, 32'h0);
        chk("first_valid", 32'(valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) wait_cfg = 2;
            step();
            chk("zw_pc", pc, 32'(k * 4));
            chk("zw_valid", 32'(valid), 32'h1);
            if (k < 3) begin
                chk("wrap_pc", pc1, RPC1 + 32'(k * 4));
                chk("wrap_valid", 32'(valid1), 32'h1);
            end
        end

        // Two wait states per word.
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 2; w++) begin
                step();
                chk("ws_valid", 32'(valid), 32'h0);
                chk("ws_inst", inst, 32'h0);
                chk("ws_addr", addr, 32'(16 + 4 * n));
            end
            if (n == 1) wait_cfg = 0;
            step();
            chk("ws_pc", pc, 32'(16 + 4 * n));
            chk("ws_dvalid", 32'(valid), 32'h1);
        end

        // Three-cycle stall with the ack landing on the first stall cycle.
        stall = 1'b1;
        step();
        chk("hold_pc", pc, 32'd20);
        chk("hold_req", 32'(req), 32'h0);
        step(); step();
        chk("hold_req3", 32'(req), 32'h0);
        chk("hold_valid3", 32'(valid), 32'h1);
        stall = 1'b0;
        step();
        chk("release_pc", pc, 32'd24);
        chk("release_valid", 32'(valid), 32'h1);
        chk("release_addr", addr, 32'd28);
        step();
        chk("after_pc", pc, 32'd28);
        chk("after_valid", 32'(valid), 32'h1);

        // Branch to 0x100 while the request for 0x8 is still waiting.
        rst = 1'b1; step();
        rst = 1'b0; step(); step();
        wait_cfg = 2;
        step();
        chk("br_pre_addr", addr, 32'h8);
        branch = 1'b1; target = 32'h100;
        step();
        branch = 1'b0;
        chk("br_hold_addr", addr, 32'h8);
        step();
        wait_cfg = 0;
        step();
        chk("br_drop_valid", 32'(valid), 32'h0);
        chk("br_next_addr", addr, 32'h100);
        step();
        chk("br_tgt_pc", pc, 32'h100);
        chk("br_tgt_valid", 32'(valid), 32'h1);

        // Reset during a waiting request, then a stray ack right after reset.
        wait_cfg = 2;
        step(); step();
        rst = 1'b1;
        step();
        chk("rmid_req", 32'(req), 32'h0);
        rst = 1'b0; force_ack = 1'b1; ack = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        chk("rmid_valid", 32'(valid), 32'h0);
        chk("rmid_inst", inst, 32'h0);
        chk("rmid_addr", addr, 32'h0);
        force_ack = 1'b0; wait_cfg = 0;
        mem_update();
        step();
        chk("rmid_pc", pc, 32'h0);
        chk("rmid_dvalid", 32'(valid), 32'h1);

        // Random stall/branch/wait/reset traffic.
        rand_wait = 1'b1;
        deliveries = 0;
        for (int i = 0; i < 3000; i++) begin
            stall  = ($urandom_range(3, 0) == 0);
            branch = ($urandom_range(19, 0) == 0);
            target = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                  : $urandom;
            rst    = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; branch = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("liveness", 32'(deliveries > 300), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
